// File: rtl/wb_lsu_master.sv
// wb_lsu_master: Wishbone classic initiator for the core's single-outstanding
// load/store port. It turns one request into one bus cycle, or into an
// immediate error response when the request is misaligned. Load data is
// aligned and extended, and bus error or timeout is reported as rsp_err_o.
module wb_lsu_master #(
    parameter int TIMEOUT = 256
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    // core request
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_wdata_i,
    // core response
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    // Wishbone initiator
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    // Timeout counter width follows TIMEOUT. A TIMEOUT of 0 would give
    // zero bits, so the counter keeps at least one bit.
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int CNT_W = (TO_W < 1) ? 1 : TO_W;
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_we;
    logic [1:0]         r_off;
    logic [1:0]         r_size;
    logic               r_uns;

    logic               r_rsp_valid;
    logic [31:0]        r_rsp_rdata;
    logic               r_rsp_err;
    logic               r_wb_cyc;
    logic               r_wb_stb;
    logic               r_wb_we;
    logic [31:0]        r_wb_adr;
    logic [3:0]         r_wb_sel;
    logic [31:0]        r_wb_dat;

    logic               w_hs;
    logic               w_misaligned;
    logic [3:0]         w_sel;
    logic [31:0]        w_dat;
    logic [7:0]         w_byte [4];
    logic [15:0]        w_half;
    logic [31:0]        w_load;
    logic               w_timeout;

    assign req_ready_o = (r_state == S_IDLE);
    assign w_hs        = req_valid_i & req_ready_o;
    assign w_timeout   = (TIMEOUT != 0) && (r_cnt == TO_LAST);

    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rsp_rdata;
    assign rsp_err_o   = r_rsp_err;
    assign wb_cyc_o    = r_wb_cyc;
    assign wb_stb_o    = r_wb_stb;
    assign wb_we_o     = r_wb_we;
    assign wb_adr_o    = r_wb_adr;
    assign wb_sel_o    = r_wb_sel;
    assign wb_dat_o    = r_wb_dat;

    // Byte lanes of the read bus, lane index equals byte offset in the word.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_byte[gi] = wb_dat_i[8*gi +: 8];
        end
    endgenerate

    assign w_half = r_off[1] ? wb_dat_i[31:16] : wb_dat_i[15:0];

    // Misalignment check and lane select / replicated store data for the request.
    always_comb begin
        w_misaligned = 1'b0;
        w_sel        = 4'hF;
        w_dat        = req_wdata_i;
        case (req_size_i)
            2'd0: begin
                w_sel = 4'b0001 << req_addr_i[1:0];
                w_dat = {4{req_wdata_i[7:0]}};
            end
            2'd1: begin
                w_misaligned = req_addr_i[0];
                w_sel        = 4'b0011 << req_addr_i[1:0];
                w_dat        = {2{req_wdata_i[15:0]}};
            end
            2'd2: begin
                w_misaligned = (req_addr_i[1:0] != 2'b00);
            end
            default: begin
                w_misaligned = 1'b1;
            end
        endcase
    end

    // Extract the addressed field of the read data and sign/zero extend it.
    always_comb begin
        case (r_size)
            2'd0:    w_load = {{24{~r_uns & w_byte[r_off][7]}}, w_byte[r_off]};
            2'd1:    w_load = {{16{~r_uns & w_half[15]}}, w_half};
            default: w_load = wb_dat_i;
        endcase
    end

    // Request/bus/response state machine; every output it drives is registered.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_off       <= 2'b00;
            r_size      <= 2'b00;
            r_uns       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_wb_cyc    <= 1'b0;
            r_wb_stb    <= 1'b0;
            r_wb_we     <= 1'b0;
            r_wb_adr    <= '0;
            r_wb_sel    <= '0;
            r_wb_dat    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        r_we   <= req_we_i;
                        r_off  <= req_addr_i[1:0];
                        r_size <= req_size_i;
                        r_uns  <= req_unsigned_i;
                        if (w_misaligned) begin
                            // No bus cycle: answer with an error right away.
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                        end else begin
                            r_state  <= S_ACCESS;
                            r_cnt    <= '0;
                            r_wb_cyc <= 1'b1;
                            r_wb_stb <= 1'b1;
                            r_wb_we  <= req_we_i;
                            r_wb_adr <= {req_addr_i[31:2], 2'b00};
                            r_wb_sel <= w_sel;
                            r_wb_dat <= req_we_i ? w_dat : 32'd0;
                        end
                    end
                end
                S_ACCESS: begin
                    if (wb_ack_i | wb_err_i | w_timeout) begin
                        r_state     <= S_RESP;
                        r_wb_cyc    <= 1'b0;
                        r_wb_stb    <= 1'b0;
                        r_wb_we     <= 1'b0;
                        r_wb_adr    <= '0;
                        r_wb_sel    <= '0;
                        r_wb_dat    <= '0;
                        r_rsp_valid <= 1'b1;
                        // Error beats ack; timeout only fires without either.
                        if (wb_ack_i & ~wb_err_i) begin
                            r_rsp_err   <= 1'b0;
                            r_rsp_rdata <= r_we ? 32'd0 : w_load;
                        end else begin
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    // S_RESP: one-cycle response pulse, data/err are held.
                    r_rsp_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_lsu_master.sv
// Testbench for wb_lsu_master: directed cases plus randomized requests,
// checked against a behavioural model of addressing, lane data and timing.
module tb_wb_lsu_master;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic [1:0]  req_size_i = '0;
    logic        req_unsigned_i = 1'b0;
    logic [31:0] req_wdata_i = '0;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    wb_lsu_master #(.TIMEOUT(4)) dut (
        .wb_clk_i       (wb_clk_i),
        .wb_rst_i       (wb_rst_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_addr_i     (req_addr_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_wdata_i    (req_wdata_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_rdata_o    (rsp_rdata_o),
        .rsp_err_o      (rsp_err_o),
        .wb_cyc_o       (wb_cyc_o),
        .wb_stb_o       (wb_stb_o),
        .wb_we_o        (wb_we_o),
        .wb_adr_o       (wb_adr_o),
        .wb_sel_o       (wb_sel_o),
        .wb_dat_o       (wb_dat_o),
        .wb_dat_i       (wb_dat_i),
        .wb_ack_i       (wb_ack_i),
        .wb_err_i       (wb_err_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Responder: answers after tb_waits wait states.
    // tb_mode 0=ack, 1=err, 2=ack+err, 3=never answers.
    int          tb_waits = 0;
    int          tb_mode  = 0;
    logic [31:0] tb_rdat  = '0;
    logic        stray    = 1'b0;
    int          acc_cnt  = 0;
    logic        hit;

    always @(posedge wb_clk_i) acc_cnt <= wb_cyc_o ? acc_cnt + 1 : 0;

    always_comb begin
        hit      = wb_cyc_o && wb_stb_o && (tb_mode != 3) && (acc_cnt == tb_waits);
        wb_ack_i = stray | (hit && (tb_mode == 0 || tb_mode == 2));
        wb_err_i = hit && (tb_mode == 1 || tb_mode == 2);
        wb_dat_i = hit ? tb_rdat : 32'hDEAD_BEEF;
    end

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata,
                          input int waits, input int mode, input logic [31:0] rdat);
        logic [31:0] exp_sel, exp_dat, exp_rd;
        logic        mis, exp_e;
        int          exp_n, n, sh;
        mis = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
        sh  = int'(addr[1:0]);
        exp_rd = rdat;
        case (size)
            2'd0: begin
                exp_sel = 32'd1 << sh;
                exp_dat = 32'h0101_0101 * wdata[7:0];
                exp_rd  = (rdat >> (8 * sh)) & 32'hFF;
                if (!uns && exp_rd >= 32'd128) exp_rd = exp_rd - 32'd256;
            end
            2'd1: begin
                exp_sel = 32'd3 << sh;
                exp_dat = 32'h0001_0001 * wdata[15:0];
                exp_rd  = (rdat >> (16 * (sh / 2))) & 32'hFFFF;
                if (!uns && exp_rd >= 32'd32768) exp_rd = exp_rd - 32'd65536;
            end
            default: begin
                exp_sel = 32'hF;
                exp_dat = wdata;
            end
        endcase
        if (!we) exp_dat = 32'd0;
        exp_n = (mode == 3 || waits >= 4) ? 4 : waits + 1;
        exp_e = (mode != 0) || (waits >= 4);
        if (we || exp_e) exp_rd = 32'd0;

        tb_waits = waits;
        tb_mode  = mode;
        tb_rdat  = rdat;
        @(negedge wb_clk_i);
        chk("ready_before", req_ready_o, 1);
        req_valid_i    = 1'b1;
        req_we_i       = we;
        req_addr_i     = addr;
        req_size_i     = size;
        req_unsigned_i = uns;
        req_wdata_i    = wdata;
        @(posedge wb_clk_i);
        #1;
        req_valid_i = 1'b0;
        if (mis) begin
            chk("mis_cyc", wb_cyc_o, 0);
            chk("mis_valid", rsp_valid_o, 1);
            chk("mis_err", rsp_err_o, 1);
            chk("mis_rdata", rsp_rdata_o, 0);
        end else begin
            n = 0;
            while (wb_cyc_o && n < 20) begin
                chk("stb", wb_stb_o, 1);
                chk("we", wb_we_o, we);
                chk("adr", wb_adr_o, {addr[31:2], 2'b00});
                chk("sel", wb_sel_o, exp_sel);
                chk("dat", wb_dat_o, exp_dat);
                chk("busy_valid", rsp_valid_o, 0);
                chk("busy_ready", req_ready_o, 0);
                n++;
                @(posedge wb_clk_i);
                #1;
            end
            chk("cyc_cycles", n, exp_n);
            chk("post_stb", wb_stb_o, 0);
            chk("post_we", wb_we_o, 0);
            chk("post_adr", wb_adr_o, 0);
            chk("post_sel", wb_sel_o, 0);
            chk("post_dat", wb_dat_o, 0);
            chk("rsp_valid", rsp_valid_o, 1);
            chk("rsp_err", rsp_err_o, exp_e);
            chk("rsp_rdata", rsp_rdata_o, exp_rd);
        end
        @(posedge wb_clk_i);
        #1;
        chk("valid_pulse_end", rsp_valid_o, 0);
        chk("ready_after", req_ready_o, 1);
        $display("txn we=%0d addr=%08h size=%0d uns=%0d waits=%0d mode=%0d -> err=%0d rdata=%08h",
                 we, addr, size, uns, waits, mode, rsp_err_o, rsp_rdata_o);
    endtask

    initial begin
        // Reset values
        repeat (2) @(posedge wb_clk_i);
        #1;
        chk("rst_ready", req_ready_o, 1);
        chk("rst_valid", rsp_valid_o, 0);
        chk("rst_err", rsp_err_o, 0);
        chk("rst_rdata", rsp_rdata_o, 0);
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_stb", wb_stb_o, 0);
        chk("rst_sel", wb_sel_o, 0);
        chk("rst_adr", wb_adr_o, 0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;

        // Directed cases
        do_req(1'b0, 32'h2000_0C08, 2'd2, 1'b0, 32'h0, 0, 0, 32'h0000_1234);
        do_req(1'b1, 32'h2000_0C03, 2'd0, 1'b0, 32'h0000_00A5, 0, 0, 32'h0);
        do_req(1'b0, 32'h2000_0C01, 2'd0, 1'b0, 32'h0, 0, 0, 32'h0000_8000);
        do_req(1'b0, 32'h2000_0C01, 2'd0, 1'b1, 32'h0, 0, 0, 32'h0000_8000);
        do_req(1'b0, 32'h2000_0C02, 2'd1, 1'b0, 32'h0, 1, 0, 32'h8001_0000);
        do_req(1'b0, 32'h2000_0C01, 2'd1, 1'b0, 32'h0, 0, 0, 32'h1111_1111);
        do_req(1'b0, 32'h2000_0C02, 2'd2, 1'b0, 32'h0, 0, 0, 32'h1111_1111);
        do_req(1'b1, 32'h2000_0C00, 2'd3, 1'b0, 32'h5, 0, 0, 32'h0);
        do_req(1'b0, 32'h2000_0C04, 2'd2, 1'b0, 32'h0, 0, 3, 32'h0);
        do_req(1'b0, 32'h2000_0C04, 2'd2, 1'b0, 32'h0, 1, 2, 32'h1234_5678);
        do_req(1'b1, 32'h2000_0C06, 2'd1, 1'b0, 32'hCAFE_BEEF, 2, 1, 32'h0);
        do_req(1'b0, 32'h2000_0C04, 2'd2, 1'b0, 32'h0, 3, 0, 32'h0BAD_F00D);

        // Stray ack in IDLE must be ignored
        @(negedge wb_clk_i);
        stray = 1'b1;
        @(negedge wb_clk_i);
        stray = 1'b0;
        @(posedge wb_clk_i);
        #1;
        chk("stray_valid", rsp_valid_o, 0);
        chk("stray_ready", req_ready_o, 1);

        // Reset during an access with three wait states
        tb_waits = 3;
        tb_mode  = 0;
        tb_rdat  = 32'h7777_7777;
        @(negedge wb_clk_i);
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        req_addr_i  = 32'h2000_0C10;
        req_size_i  = 2'd2;
        @(posedge wb_clk_i);
        #1;
        req_valid_i = 1'b0;
        @(posedge wb_clk_i);
        #1;
        chk("abort_cyc_before", wb_cyc_o, 1);
        #2;
        wb_rst_i = 1'b1;
        #1;
        chk("abort_cyc", wb_cyc_o, 0);
        chk("abort_stb", wb_stb_o, 0);
        chk("abort_ready", req_ready_o, 1);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge wb_clk_i);
            #1;
            chk("abort_no_rsp", {rsp_valid_o, wb_cyc_o}, 0);
        end
        do_req(1'b0, 32'h2000_0C10, 2'd2, 1'b0, 32'h0, 0, 0, 32'h0000_4321);

        // Randomized requests
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, wd, rd;
            logic [1:0]  sz;
            logic        w, u;
            int          wt, md;
            a  = $urandom;
            wd = $urandom;
            rd = $urandom;
            sz = 2'($urandom_range(0, 3));
            w  = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            wt = $urandom_range(0, 5);
            md = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            do_req(w, a, sz, u, wd, wt, md, rd);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
